// File: rtl/tt_um_odd_parity_rx.sv
// tt_um_odd_parity_rx: asynchronous serial frame receiver with odd-parity check.
// Frame format: start bit, DATA_BITS data bits LSB first, one parity bit, one stop bit.
// The received word and the valid, parity, framing and overrun flags stay on uo_out
// until ack (ui_in[1]) clears the flags.
// Optional macro ODD_PARITY_RX_ERRCNT_EN adds a saturating error counter on uio_out.
module tt_um_odd_parity_rx #(
   parameter int CLKS_PER_BIT = 8,
   parameter int DATA_BITS    = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int              CW         = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0]   HALF_C     = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0]   FULL_C     = CW'(CLKS_PER_BIT);
   localparam logic [CW-1:0]   ONE_C      = CW'(1);
   localparam logic [2:0]      LAST_BIT_C = 3'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t               state_q, state_d;
   logic                 meta_q, rxs_q;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_q;
   logic [3:0]           data_q;
   logic                 valid_q, perr_q, ferr_q, ovr_q;

   logic                 tick;
   logic                 shift_en;
   logic                 par_en;
   logic                 complete;
   logic                 ack;
   logic                 parity_bad;
   logic [DATA_BITS:0]   shift_cat;
   logic [3:0]           data_ext;

   assign ack = ui_in[1];

   // Only ui_in[0] and ui_in[1] carry meaning; everything else is tied off here.
   logic unused_ok;
   assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:2]};

   // Two-flop synchronizer for the serial line; presets to idle-high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         rxs_q  <= 1'b1;
      end else begin
         meta_q <= ui_in[0];
         rxs_q  <= meta_q;
      end
   end

   // State register plus the bit-timing and bit-index counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
      end
   end

   // FSM outputs: sample strobes derived from state and the cycle counter.
   always_comb begin
      tick = 1'b0;
      case (state_q)
         S_START:                  tick = (cnt_q == HALF_C);
         S_DATA, S_PARITY, S_STOP: tick = (cnt_q == FULL_C);
         default:                  tick = 1'b0;
      endcase
      shift_en = (state_q == S_DATA)   && tick;
      par_en   = (state_q == S_PARITY) && tick;
      complete = (state_q == S_STOP)   && tick;
   end

   // Next state; cnt counts cycles since the start edge or the previous sample.
   always_comb begin
      state_d = state_q;
      cnt_d   = tick ? ONE_C : cnt_q + ONE_C;
      bit_d   = shift_en ? bit_q + 3'd1 : bit_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = ONE_C;
            bit_d = '0;
            if (!rxs_q) state_d = S_START;
         end
         S_START: begin
            if (tick) state_d = rxs_q ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (tick && (bit_q == LAST_BIT_C)) state_d = S_PARITY;
         end
         S_PARITY: begin
            if (tick) state_d = S_STOP;
         end
         S_STOP: begin
            if (tick) state_d = rxs_q ? S_IDLE : S_BREAK;
         end
         S_BREAK: begin
            cnt_d = ONE_C;
            if (rxs_q) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Shift-in path and completion values (word, parity verdict).
   always_comb begin
      shift_cat  = {rxs_q, shift_q};
      data_ext   = '0;
      data_ext[DATA_BITS-1:0] = shift_q;
      parity_bad = ~((^shift_q) ^ par_q);
   end

   // Data bits are shifted in LSB first; the parity bit is held for the stop sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         par_q   <= 1'b0;
      end else begin
         if (shift_en) shift_q <= shift_cat[DATA_BITS:1];
         if (par_en)   par_q   <= rxs_q;
      end
   end

   // Result register: completion loads new word and flags (and wins over ack).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else if (complete) begin
         data_q  <= data_ext;
         valid_q <= 1'b1;
         perr_q  <= parity_bad;
         ferr_q  <= ~rxs_q;
         ovr_q   <= ~ack & (valid_q | ovr_q);
      end else if (ack) begin
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end
   end

   assign uo_out = {ovr_q, ferr_q, perr_q, valid_q, data_q};

`ifdef ODD_PARITY_RX_ERRCNT_EN
   logic [7:0] errcnt_q;

   // Saturating count of frames completed with a parity or framing error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         errcnt_q <= '0;
      end else if (complete && (parity_bad || !rxs_q) && (errcnt_q != 8'hFF)) begin
         errcnt_q <= errcnt_q + 8'd1;
      end
   end

   assign uio_out = errcnt_q;
   assign uio_oe  = 8'hFF;
`else
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_tt_um_odd_parity_rx.sv
// Directed testbench for tt_um_odd_parity_rx (CLKS_PER_BIT = 8, DATA_BITS = 3).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_tt_um_odd_parity_rx;

   localparam int CPB = 8;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int total;
   int bad;

   logic [7:0] exp_oe;
   logic [7:0] exp_cnt_perr;
   logic [7:0] exp_cnt_break;

   tt_um_odd_parity_rx #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (3)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .ui_in  (ui_in),
      .uo_out (uo_out),
      .uio_in (uio_in),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_bit(input logic b);
      ui_in[0] = b;
      step(CPB);
   endtask

   task automatic send_frame(input logic [2:0] d, input logic p, input logic s);
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(d[i]);
      drive_bit(p);
      drive_bit(s);
      ui_in[0] = 1'b1;
   endtask

   task automatic pulse_ack();
      ui_in[1] = 1'b1;
      step(1);
      ui_in[1] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(3);
      total++;
      if (uo_out !== 8'h00) begin
         bad++;
         $display("FAIL reset_uo_out: got %h expected 00", uo_out);
      end
      total++;
      if (uio_out !== 8'h00) begin
         bad++;
         $display("FAIL reset_uio_out: got %h expected 00", uio_out);
      end
      total++;
      if (uio_oe !== exp_oe) begin
         bad++;
         $display("FAIL reset_uio_oe: got %h expected %h", uio_oe, exp_oe);
      end
      rst_n = 1'b1;
      step(4);
      $display("reset: uo_out=%h uio_out=%h uio_oe=%h", uo_out, uio_out, uio_oe);
   endtask

   task automatic test_glitch();
      ui_in[0] = 1'b0;
      step(2);
      ui_in[0] = 1'b1;
      step(60);
      total++;
      if (uo_out !== 8'h00) begin
         bad++;
         $display("FAIL glitch_ignored: got %h expected 00", uo_out);
      end
      $display("glitch: uo_out=%h", uo_out);
   endtask

   task automatic test_good_frame();
      // 3'b101 sent LSB first as 1,0,1 with p=1, stop=1
      ui_in[0] = 1'b0;
      step(CPB);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      ui_in[0] = 1'b1;
      step(6);
      total++;
      if (uo_out[4] !== 1'b0) begin
         bad++;
         $display("FAIL good_latency_early: rx_valid=%b at cycle 46 expected 0", uo_out[4]);
      end
      step(1);
      total++;
      if (uo_out !== 8'h15) begin
         bad++;
         $display("FAIL good_frame_101: got %h at cycle 47 expected 15", uo_out);
      end
      $display("good frame 101: uo_out=%h", uo_out);
      step(1);
      pulse_ack();
      total++;
      if (uo_out !== 8'h05) begin
         bad++;
         $display("FAIL good_ack: got %h expected 05", uo_out);
      end
      step(4);
   endtask

   task automatic test_parity_err();
      // 3'b011 with p=0: total weight even -> parity error
      send_frame(3'b011, 1'b0, 1'b1);
      step(2);
      total++;
      if (uo_out !== 8'h33) begin
         bad++;
         $display("FAIL parity_err_frame: got %h expected 33", uo_out);
      end
      total++;
      if (uio_out !== exp_cnt_perr || uio_oe !== exp_oe) begin
         bad++;
         $display("FAIL parity_errcnt: got uio_out=%h uio_oe=%h expected %h %h",
                  uio_out, uio_oe, exp_cnt_perr, exp_oe);
      end
      $display("parity err frame: uo_out=%h uio_out=%h", uo_out, uio_out);
      pulse_ack();
      step(4);
   endtask

   task automatic test_break();
      // 3'b101, p=1, stop bit 0, then line stays low for 100 cycles in total
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      ui_in[0] = 1'b0;
      step(CPB);
      total++;
      if (uo_out !== 8'h55) begin
         bad++;
         $display("FAIL break_frame_err: got %h expected 55", uo_out);
      end
      total++;
      if (uio_out !== exp_cnt_break) begin
         bad++;
         $display("FAIL break_errcnt: got %h expected %h", uio_out, exp_cnt_break);
      end
      pulse_ack();
      step(91);
      total++;
      if (uo_out !== 8'h05) begin
         bad++;
         $display("FAIL break_no_new_frame: got %h expected 05", uo_out);
      end
      ui_in[0] = 1'b1;
      step(10);
      send_frame(3'b110, 1'b1, 1'b1);
      step(2);
      total++;
      if (uo_out !== 8'h16) begin
         bad++;
         $display("FAIL break_recovery: got %h expected 16", uo_out);
      end
      $display("break: recovered frame uo_out=%h", uo_out);
      pulse_ack();
      step(4);
   endtask

   task automatic test_back_to_back();
      send_frame(3'b001, 1'b0, 1'b1);
      step(2);
      total++;
      if (uo_out !== 8'h11) begin
         bad++;
         $display("FAIL b2b_first: got %h expected 11", uo_out);
      end
      send_frame(3'b110, 1'b1, 1'b1);
      step(2);
      total++;
      if (uo_out !== 8'h96) begin
         bad++;
         $display("FAIL b2b_overrun: got %h expected 96", uo_out);
      end
      $display("back to back: uo_out=%h", uo_out);
      pulse_ack();
      total++;
      if (uo_out !== 8'h06) begin
         bad++;
         $display("FAIL b2b_ack: got %h expected 06", uo_out);
      end
      step(4);
   endtask

   task automatic test_ack_collision();
      send_frame(3'b001, 1'b0, 1'b1);
      step(2);
      // 3'b010, p=0; ack is high only on the completion edge (cycle 47)
      ui_in[0] = 1'b0;
      step(CPB);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b0);
      ui_in[0] = 1'b1;
      step(6);
      ui_in[1] = 1'b1;
      step(1);
      ui_in[1] = 1'b0;
      total++;
      if (uo_out !== 8'h12) begin
         bad++;
         $display("FAIL ack_collision: got %h expected 12", uo_out);
      end
      $display("ack collision: uo_out=%h", uo_out);
      step(4);
   endtask

   task automatic test_reset_midframe();
      // uo_out holds 8'h12 unacknowledged from the previous scenario
      drive_bit(1'b0);
      drive_bit(1'b1);
      ui_in[0] = 1'b0;
      step(4);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
         bad++;
         $display("FAIL midframe_async_reset: got uo_out=%h uio_out=%h expected 00 00",
                  uo_out, uio_out);
      end
      ui_in[0] = 1'b1;
      step(2);
      rst_n = 1'b1;
      step(20);
      send_frame(3'b111, 1'b0, 1'b1);
      step(2);
      total++;
      if (uo_out !== 8'h17) begin
         bad++;
         $display("FAIL midframe_next_frame: got %h expected 17", uo_out);
      end
      $display("reset mid-frame: next frame uo_out=%h", uo_out);
   endtask

   initial begin
      total  = 0;
      bad    = 0;
`ifdef ODD_PARITY_RX_ERRCNT_EN
      exp_oe        = 8'hFF;
      exp_cnt_perr  = 8'd1;
      exp_cnt_break = 8'd2;
`else
      exp_oe        = 8'h00;
      exp_cnt_perr  = 8'd0;
      exp_cnt_break = 8'd0;
`endif
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h01;
      uio_in = 8'h00;
      step(1);
      test_reset();
      test_glitch();
      test_good_frame();
      test_parity_err();
      test_break();
      test_back_to_back();
      test_ack_collision();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
